// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide engine sitting in EX, feeding the HILO pair.
// A start pulse in IDLE launches MULT/MULTU/DIV/DIVU. The engine runs 32 radix-2
// iterations, applies signs, then pulses done for one cycle with {hi,lo} valid.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   start      launch request, sampled only in IDLE
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a  multiplicand / dividend (rs)
//   operand_b  multiplier / divisor (rt)
//   cancel     pipeline flush, aborts any operation in progress
//   busy       high whenever the engine is not IDLE
//   done       one-cycle pulse, hi_result/lo_result valid (HILO write_en)
//   hi_result  MUL: product high word, DIV: remainder
//   lo_result  MUL: product low word,  DIV: quotient
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_result,
    output logic [DATA_WIDTH-1:0] lo_result
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] counter;
    logic [W-1:0]     m_op;      // MUL: |multiplicand|, DIV: |divisor|
    logic [2*W-1:0]   acc;       // MUL: {partial product, multiplier}; DIV: dividend/quotient in [W-1:0]
    logic [W:0]       rem;       // DIV partial remainder; raw dividend on divide-by-zero
    logic             neg_q;     // negate product/quotient
    logic             neg_r;     // negate remainder (sign of dividend)
    logic             div_zero;

    // Operand magnitudes; signs only matter for the signed ops (op[0]==0).
    logic         a_neg, b_neg;
    logic [W-1:0] a_abs, b_abs;

    // One iteration of each datapath.
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W+1:0] div_diff;

    // Sign-corrected results.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   fix_hi, fix_lo;

    // NOTE: every combinational output is assigned a default first so no latch is inferred.
    always_comb begin
        a_neg = ~op[0] & operand_a[W-1];
        b_neg = ~op[0] & operand_b[W-1];
        a_abs = a_neg ? -operand_a : operand_a;
        b_abs = b_neg ? -operand_b : operand_b;

        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m_op} : '0);
        div_shift = {rem[W-1:0], acc[W-1]};
        // Extra top bit makes the borrow of shift-minus-divisor visible.
        div_diff  = {1'b0, div_shift} - {2'b0, m_op};

        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[2*W-1:W];
        fix_lo   = prod_fix[W-1:0];
        if (op_r[1]) begin
            if (div_zero) begin
                fix_hi = rem[W-1:0];
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -rem[W-1:0] : rem[W-1:0];
                fix_lo = neg_q ? -acc[W-1:0] : acc[W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too; it is cheap here and keeps the engine fully deterministic.
            state     <= IDLE;
            op_r      <= '0;
            counter   <= '0;
            m_op      <= '0;
            acc       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi_result <= '0;
            lo_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // cancel beats start: a flushed instruction must not launch.
                    if (start && !cancel) begin
                        op_r    <= op;
                        counter <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        busy    <= 1'b1;
                        if (op[1] && operand_b == '0) begin
                            // Divide by zero: no iterations, hi returns the raw dividend.
                            div_zero <= 1'b1;
                            rem      <= {1'b0, operand_a};
                            acc      <= '0;
                            m_op     <= '0;
                            state    <= FIX;
                        end else begin
                            div_zero <= 1'b0;
                            rem      <= '0;
                            m_op     <= op[1] ? b_abs : a_abs;
                            acc      <= {{W{1'b0}}, (op[1] ? a_abs : b_abs)};
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (op_r[1]) begin
                            // Restoring step: keep the difference only when it did not borrow.
                            if (!div_diff[W+1]) begin
                                rem <= div_diff[W:0];
                                acc <= {acc[2*W-1:W], acc[W-2:0], 1'b1};
                            end else begin
                                rem <= div_shift;
                                acc <= {acc[2*W-1:W], acc[W-2:0], 1'b0};
                            end
                        end else begin
                            // Add into the high half, then shift the whole accumulator right.
                            acc <= {mul_sum, acc[W-1:1]};
                        end
                        counter <= counter + 1'b1;
                        if (counter == CNT_W'(W - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hi_result <= fix_hi;
                        lo_result <= fix_lo;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Same exit whether or not cancel is asserted.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {hi,lo} pairs are queued when an
// operation is launched and compared when done pulses; latency, busy and the
// reset/cancel/ignored-start cases are checked alongside.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi_result;
    logic [31:0] lo_result;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi_result (hi_result),
        .lo_result (lo_result)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model, independent of the iterative hardware algorithm.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_v, q, r;
        logic [63:0] ua, ub, res;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        res  = '0;
        case (mop)
            2'b00: res = 64'(sa * sb_v);
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (mop == 2'b10) begin
                    q   = sa / sb_v;
                    r   = sa % sb_v;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {(ua % ub), 32'h0} | {32'h0, (ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (done === 1'b1) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hi_result", {32'h0, hi_result}, {32'h0, e[63:32]});
                check("lo_result", {32'h0, lo_result}, {32'h0, e[31:0]});
            end
        end
    end

    // Waits (bounded) for done; latency counted in posedges after the launch negedge.
    task automatic wait_done(input string tag, input int exp_lat);
        int cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (done !== 1'b1 && cyc < 100);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
        check({tag, "_idle_busy"}, {63'h0, busy}, 64'h0);
    endtask

    task automatic launch(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = mop; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic run(input string tag, input logic [1:0] mop, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        sb.push_back(exp);
        last_exp = exp;
        launch(mop, a, b);
        wait_done(tag, (mop[1] && b == 32'h0) ? 1 : 33);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hilo", {hi_result, lo_result}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases.
        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run("divu",      2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
        run("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("divu_zero", 2'b11, 32'h0000_1234, 32'h0,         64'h0000_1234_FFFF_FFFF);
        run("div_zero",  2'b10, 32'hFFFF_FFFB, 32'h0,         64'hFFFF_FFFB_FFFF_FFFF);

        // Random operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'h0 : $urandom;
            run("random", rop, ra, rb, model(rop, ra, rb));
        end

        // start during CALC is ignored; the first result stands and no second done follows.
        sb.push_back(64'd300);
        last_exp = 64'd300;
        launch(2'b01, 32'd100, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b11; operand_a = 32'd55; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_in_calc", 27);
        repeat (40) @(posedge clk);
        #1;
        check("start_in_calc_idle", {63'h0, busy}, 64'h0);

        // Cancel ten cycles into CALC: no done, results untouched.
        launch(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        cancel = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hilo_hold", {hi_result, lo_result}, last_exp);

        // start and cancel together in IDLE: nothing launches.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge clk); #1;
        check("start_cancel_idle", {63'h0, busy}, 64'h0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("start_cancel_hilo", {hi_result, lo_result}, last_exp);

        // Reset held for two cycles mid-CALC: outputs clear, no done ever follows.
        launch(2'b11, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        check("midrst_hilo", {hi_result, lo_result}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done_busy", {63'h0, busy}, 64'h0);
        check("midrst_hilo_after", {hi_result, lo_result}, 64'h0);

        // A normal operation still works after the abort.
        run("post_reset", 2'b01, 32'd6, 32'd7, 64'd42);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
